// File: rtl/lms_coef_updater.sv
// lms_coef_updater: sequential LMS update of a TAPS-long coefficient bank, one tap per clock
module lms_coef_updater #(
    parameter int TAPS     = 32,
    parameter int MU_SHIFT = 12,
    localparam int AW      = $clog2(TAPS)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic signed [15:0]   sample_in,
    input  logic                 sample_ready,
    input  logic signed [15:0]   error_in,
    input  logic                 error_ready,
    input  logic                 clear_coef_in,
    input  logic [AW-1:0]        coef_idx_in,
    output logic signed [15:0]   coef_out,
    output logic                 busy_out,
    output logic                 done_out,
    output logic                 error_dropped_out,
    output logic                 sample_dropped_out
);
    typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      k_q, k_d;
    logic signed [15:0] e_q, e_d;
    logic signed [15:0] w_q [TAPS];
    logic signed [15:0] w_d [TAPS];
    logic signed [15:0] x_q [TAPS];
    logic signed [15:0] x_d [TAPS];
    logic signed [15:0] pend_q, pend_d;
    logic               pend_v_q, pend_v_d;
    logic signed [15:0] coef_q, coef_d;
    logic               err_drop_q, err_drop_d;
    logic               smp_drop_q, smp_drop_d;
    logic signed [31:0] prod;
    logic signed [31:0] delta;
    logic signed [32:0] sum;
    logic signed [15:0] w_new;
    logic               push_pend;
    logic               push_smp;

    assign coef_out           = coef_q;
    assign busy_out           = state_q != IDLE;
    assign done_out           = state_q == DONE;
    assign error_dropped_out  = err_drop_q;
    assign sample_dropped_out = smp_drop_q;

    // Tap arithmetic: full product, floor shift, wide sum so saturation never sees a wrapped value
    always_comb begin
        prod  = 32'(e_q) * 32'(x_q[k_q]);
        delta = prod >>> MU_SHIFT;
        sum   = 33'(w_q[k_q]) + 33'(delta);
        w_new = sum > 33'sd32767 ? 16'sh7fff : sum < -33'sd32768 ? 16'sh8000 : sum[15:0];
    end

    // Next-state: FSM sequencing, history pushes (pending before live), coefficient writes and clear
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        e_d        = e_q;
        w_d        = w_q;
        x_d        = x_q;
        pend_d     = pend_q;
        pend_v_d   = pend_v_q;
        coef_d     = w_q[coef_idx_in];
        err_drop_d = error_ready && state_q != IDLE;
        smp_drop_d = 1'b0;
        push_pend  = 1'b0;
        push_smp   = 1'b0;
        unique case (state_q)
            IDLE: begin
                push_smp = sample_ready;
                if (!clear_coef_in && error_ready) begin
                    e_d     = error_in;
                    k_d     = '0;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                if (clear_coef_in) begin
                    state_d   = IDLE;
                    push_pend = pend_v_q;
                    push_smp  = sample_ready;
                    pend_v_d  = 1'b0;
                end else begin
                    w_d[k_q] = w_new;
                    k_d      = k_q + AW'(1);
                    state_d  = k_q == AW'(TAPS - 1) ? DONE : UPDATE;
                    if (sample_ready) begin
                        pend_d     = sample_in;
                        pend_v_d   = 1'b1;
                        smp_drop_d = pend_v_q;
                    end
                end
            end
            DONE: begin
                state_d   = IDLE;
                push_pend = pend_v_q;
                push_smp  = sample_ready;
                pend_v_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (push_pend) begin
            for (int i = TAPS - 1; i > 0; i--) x_d[i] = x_d[i-1];
            x_d[0] = pend_q;
        end
        if (push_smp) begin
            for (int i = TAPS - 1; i > 0; i--) x_d[i] = x_d[i-1];
            x_d[0] = sample_in;
        end
        if (clear_coef_in) begin
            for (int i = 0; i < TAPS; i++) w_d[i] = '0;
        end
    end

    // State registers with synchronous reset back to the empty, idle condition
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            k_q        <= '0;
            e_q        <= '0;
            w_q        <= '{default: '0};
            x_q        <= '{default: '0};
            pend_q     <= '0;
            pend_v_q   <= 1'b0;
            coef_q     <= '0;
            err_drop_q <= 1'b0;
            smp_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            e_q        <= e_d;
            w_q        <= w_d;
            x_q        <= x_d;
            pend_q     <= pend_d;
            pend_v_q   <= pend_v_d;
            coef_q     <= coef_d;
            err_drop_q <= err_drop_d;
            smp_drop_q <= smp_drop_d;
        end
    end
endmodule

// File: tb/tb_lms_coef_updater.sv
// tb_lms_coef_updater: directed scenario tests for the LMS coefficient updater
module tb_lms_coef_updater;
    localparam int TAPS = 32;
    localparam int MU_SHIFT = 12;

    logic               clk_in = 1'b0;
    logic               rst_in = 1'b1;
    logic signed [15:0] sample_in = '0;
    logic               sample_ready = 1'b0;
    logic signed [15:0] error_in = '0;
    logic               error_ready = 1'b0;
    logic               clear_coef_in = 1'b0;
    logic [4:0]         coef_idx_in = '0;
    logic signed [15:0] coef_out;
    logic               busy_out;
    logic               done_out;
    logic               error_dropped_out;
    logic               sample_dropped_out;

    int checks = 0;
    int errors = 0;
    logic signed [15:0] v;
    int nd;

    lms_coef_updater #(.TAPS(TAPS), .MU_SHIFT(MU_SHIFT)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .sample_in(sample_in), .sample_ready(sample_ready),
        .error_in(error_in), .error_ready(error_ready), .clear_coef_in(clear_coef_in),
        .coef_idx_in(coef_idx_in), .coef_out(coef_out), .busy_out(busy_out), .done_out(done_out),
        .error_dropped_out(error_dropped_out), .sample_dropped_out(sample_dropped_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        sample_ready = 1'b0;
        error_ready = 1'b0;
        clear_coef_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic push(input logic signed [15:0] s);
        sample_in = s;
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < TAPS + 4 && !done_out; i++) tick();
        if (!done_out) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got done_out=0 exp 1 within %0d cycles", TAPS + 4);
        end
        tick();
    endtask

    task automatic run_pass(input logic signed [15:0] e);
        error_in = e;
        error_ready = 1'b1;
        tick();
        error_ready = 1'b0;
        wait_done();
    endtask

    task automatic read_coef(input int idx, output logic signed [15:0] r);
        coef_idx_in = 5'(idx);
        tick();
        r = coef_out;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick();
        tick();
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_out); end
        checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_out); end
        checks++; if (error_dropped_out !== 1'b0) begin errors++; $display("FAIL reset_edrop got %b exp 0", error_dropped_out); end
        checks++; if (sample_dropped_out !== 1'b0) begin errors++; $display("FAIL reset_sdrop got %b exp 0", sample_dropped_out); end
        checks++; if (coef_out !== 16'sd0) begin errors++; $display("FAIL reset_coef got %0d exp 0", coef_out); end
        rst_in = 1'b0;
        read_coef(31, v);
        checks++; if (v !== 16'sd0) begin errors++; $display("FAIL reset_w31 got %0d exp 0", v); end
    endtask

    task automatic test_basic();
        do_reset();
        push(16'sd100);
        error_in = 16'sd4096;
        error_ready = 1'b1;
        tick();
        error_ready = 1'b0;
        checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy_out); end
        checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL basic_early_done got %b exp 0", done_out); end
        repeat (TAPS - 1) tick();
        checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL basic_done_n_plus_taps got %b exp 0", done_out); end
        tick();
        checks++; if (done_out !== 1'b1) begin errors++; $display("FAIL basic_done_pulse got %b exp 1", done_out); end
        tick();
        checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL basic_done_after got %b exp 0", done_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b exp 0", busy_out); end
        read_coef(0, v);
        checks++; if (v !== 16'sd100) begin errors++; $display("FAIL basic_w0 got %0d exp 100", v); end
        read_coef(1, v);
        checks++; if (v !== 16'sd0) begin errors++; $display("FAIL basic_w1 got %0d exp 0", v); end
        read_coef(31, v);
        checks++; if (v !== 16'sd0) begin errors++; $display("FAIL basic_w31 got %0d exp 0", v); end
    endtask

    task automatic test_floor();
        do_reset();
        sample_in = 16'sd1;
        sample_ready = 1'b1;
        error_in = -16'sd1;
        error_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        error_ready = 1'b0;
        wait_done();
        read_coef(0, v);
        checks++; if (v !== -16'sd1) begin errors++; $display("FAIL floor_neg_w0 got %0d exp -1", v); end
        read_coef(1, v);
        checks++; if (v !== 16'sd0) begin errors++; $display("FAIL floor_neg_w1 got %0d exp 0", v); end
        run_pass(16'sd1);
        read_coef(0, v);
        checks++; if (v !== -16'sd1) begin errors++; $display("FAIL floor_pos_w0 got %0d exp -1", v); end
    endtask

    task automatic test_saturation();
        do_reset();
        push(16'sd32767);
        run_pass(16'sd2048);
        read_coef(0, v);
        checks++; if (v !== 16'sd16383) begin errors++; $display("FAIL sat_pre1 got %0d exp 16383", v); end
        run_pass(16'sd2048);
        read_coef(0, v);
        checks++; if (v !== 16'sd32766) begin errors++; $display("FAIL sat_pre2 got %0d exp 32766", v); end
        run_pass(16'sd32767);
        read_coef(0, v);
        checks++; if (v !== 16'sd32767) begin errors++; $display("FAIL sat_pos got %0d exp 32767", v); end
        read_coef(1, v);
        checks++; if (v !== 16'sd0) begin errors++; $display("FAIL sat_w1 got %0d exp 0", v); end
        do_reset();
        push(16'sd32767);
        run_pass(-16'sd2048);
        read_coef(0, v);
        checks++; if (v !== -16'sd16384) begin errors++; $display("FAIL sat_pre_neg got %0d exp -16384", v); end
        run_pass(16'sh8000);
        read_coef(0, v);
        checks++; if (v !== 16'sh8000) begin errors++; $display("FAIL sat_neg got %0d exp -32768", v); end
    endtask

    task automatic test_error_drop();
        do_reset();
        push(16'sd100);
        error_in = 16'sd4096;
        error_ready = 1'b1;
        tick();
        error_ready = 1'b0;
        tick();
        tick();
        error_in = 16'sd8192;
        error_ready = 1'b1;
        tick();
        error_ready = 1'b0;
        checks++; if (error_dropped_out !== 1'b1) begin errors++; $display("FAIL edrop_pulse got %b exp 1", error_dropped_out); end
        checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL edrop_busy got %b exp 1", busy_out); end
        tick();
        checks++; if (error_dropped_out !== 1'b0) begin errors++; $display("FAIL edrop_clear got %b exp 0", error_dropped_out); end
        nd = 0;
        repeat (TAPS + 6) begin
            tick();
            if (done_out) nd++;
        end
        checks++; if (nd !== 1) begin errors++; $display("FAIL edrop_done_count got %0d exp 1", nd); end
        read_coef(0, v);
        checks++; if (v !== 16'sd100) begin errors++; $display("FAIL edrop_w0 got %0d exp 100", v); end
    endtask

    task automatic test_sample_drop();
        do_reset();
        push(16'sd5);
        error_in = 16'sd0;
        error_ready = 1'b1;
        tick();
        error_ready = 1'b0;
        tick();
        push(16'sd7);
        checks++; if (sample_dropped_out !== 1'b0) begin errors++; $display("FAIL sdrop_first got %b exp 0", sample_dropped_out); end
        tick();
        push(16'sd9);
        checks++; if (sample_dropped_out !== 1'b1) begin errors++; $display("FAIL sdrop_pulse got %b exp 1", sample_dropped_out); end
        tick();
        checks++; if (sample_dropped_out !== 1'b0) begin errors++; $display("FAIL sdrop_clear got %b exp 0", sample_dropped_out); end
        wait_done();
        run_pass(16'sd4096);
        read_coef(0, v);
        checks++; if (v !== 16'sd9) begin errors++; $display("FAIL sdrop_x0 got %0d exp 9", v); end
        read_coef(1, v);
        checks++; if (v !== 16'sd5) begin errors++; $display("FAIL sdrop_x1 got %0d exp 5", v); end
        read_coef(2, v);
        checks++; if (v !== 16'sd0) begin errors++; $display("FAIL sdrop_x2 got %0d exp 0", v); end
    endtask

    task automatic test_clear();
        do_reset();
        push(16'sd100);
        run_pass(16'sd4096);
        push(16'sd50);
        error_in = 16'sd4096;
        error_ready = 1'b1;
        tick();
        error_ready = 1'b0;
        tick();
        tick();
        push(16'sd7);
        tick();
        tick();
        clear_coef_in = 1'b1;
        tick();
        clear_coef_in = 1'b0;
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL clear_busy got %b exp 0", busy_out); end
        checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL clear_done got %b exp 0", done_out); end
        nd = 0;
        repeat (TAPS + 4) begin
            tick();
            if (done_out) nd++;
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL clear_no_done got %0d exp 0", nd); end
        read_coef(0, v);
        checks++; if (v !== 16'sd0) begin errors++; $display("FAIL clear_w0 got %0d exp 0", v); end
        read_coef(1, v);
        checks++; if (v !== 16'sd0) begin errors++; $display("FAIL clear_w1 got %0d exp 0", v); end
        read_coef(31, v);
        checks++; if (v !== 16'sd0) begin errors++; $display("FAIL clear_w31 got %0d exp 0", v); end
        run_pass(16'sd4096);
        read_coef(0, v);
        checks++; if (v !== 16'sd7) begin errors++; $display("FAIL clear_pend_x0 got %0d exp 7", v); end
        read_coef(1, v);
        checks++; if (v !== 16'sd50) begin errors++; $display("FAIL clear_pend_x1 got %0d exp 50", v); end
        read_coef(2, v);
        checks++; if (v !== 16'sd100) begin errors++; $display("FAIL clear_pend_x2 got %0d exp 100", v); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_floor();
        test_saturation();
        test_error_drop();
        test_sample_drop();
        test_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
